// File: rtl/sensor_cmd_dispatcher_pkg.sv
// Shared definitions for the sensor command dispatcher and the sensor controllers it drives.
package sensor_cmd_dispatcher_pkg;

    localparam int unsigned CmdWidth   = 4;
    localparam int unsigned AddrWidth  = 5;
    localparam int unsigned NumSensors = 8;
    localparam int unsigned SelWidth   = 3;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitAddr = 2'd1,
        StDispatch = 2'd2
    } state_e;

    // Command codes understood by the sensor controllers.
    typedef enum logic [CmdWidth-1:0] {
        CmdNop       = 4'h0,
        CmdReadTemp  = 4'h1,
        CmdReadHumid = 4'h2,
        CmdReadPress = 4'h3,
        CmdCalibrate = 4'h4,
        CmdReset     = 4'h5,
        CmdSleep     = 4'h6,
        CmdWake      = 4'h7
    } cmd_code_e;

    function automatic logic [NumSensors-1:0] sensor_onehot(input logic [SelWidth-1:0] idx);
        logic [NumSensors-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles, expired when it reaches TIMEOUT_CYCLES-1.
module cmd_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntWidth-1:0] count_q, count_d;

    assign expired = (count_q == CntWidth'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sensor_cmd_dispatcher.sv
// Decodes two-byte host frames (command, address) and hands the command to one sensor controller.
module sensor_cmd_dispatcher
    import sensor_cmd_dispatcher_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned NUM_SENSORS    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_done,
    input  logic [NUM_SENSORS-1:0] cmd_ack,
    output logic [CmdWidth-1:0]    cmd_out,
    output logic [AddrWidth-1:0]   addr_out,
    output logic [NUM_SENSORS-1:0] cmd_valid,
    output logic                   cmd_error,
    output logic                   overrun,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [CmdWidth-1:0]    cmd_q, cmd_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [NUM_SENSORS-1:0] valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   ovr_q, ovr_d;
    logic                   expired;

    // Timer only runs while waiting for the address byte; any other state holds it at zero.
    cmd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != StWaitAddr),
        .enable ((state_q == StWaitAddr) && !rx_done),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_done) begin
                    if (rx_data[7:4] == 4'h0) begin
                        cmd_d   = rx_data[CmdWidth-1:0];
                        state_d = StWaitAddr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWaitAddr: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_done) begin
                    if (rx_data[7:3] == 5'h00) begin
                        addr_d  = rx_data[AddrWidth-1:0];
                        valid_d = sensor_onehot(rx_data[SelWidth-1:0]);
                        state_d = StDispatch;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StDispatch: begin
                if (cmd_ack[addr_q[SelWidth-1:0]]) begin
                    valid_d = '0;
                    state_d = StIdle;
                end
                if (rx_done) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            addr_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cmd_out   = cmd_q;
    assign addr_out  = addr_q;
    assign cmd_valid = valid_q;
    assign cmd_error = err_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/sensor_cmd_dispatcher.md
SENSOR_CMD_DISPATCHER -- requirements
Module: sensor_cmd_dispatcher

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, max clk cycles allowed between command byte and address byte (1 s at 50 MHz).
REQ-002 SHALL have parameter NUM_SENSORS, default 8, fixed at 8 (address field decodes 3 bits); other values unsupported.
REQ-003 Port: clk  input  1  board clock, 50 MHz; one clock domain; reset is asynchronous and active-low.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: rx_data  input  8  byte from the UART receiver, valid when rx_done=1.
REQ-006 Port: rx_done  input  1  one-cycle pulse per received byte.
REQ-007 Port: cmd_ack  input  8  per-sensor-controller acknowledge; bit i = controller i accepted the command.
REQ-008 Port: cmd_out  output  4  latched command code, shared by all controllers.
REQ-009 Port: addr_out  output  5  latched sensor address, shared by all controllers.
REQ-010 Port: cmd_valid  output  8  one-hot request to controller addr_out[2:0]; all-zero when idle.
REQ-011 Port: cmd_error  output  1  one-cycle pulse: malformed byte, invalid address or inter-byte timeout.
REQ-012 Port: overrun  output  1  one-cycle pulse: byte received while dispatching, byte dropped.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 Host frame: byte 1 = command, bits[7:4]=0, code in bits[3:0]; byte 2 = address, bits[7:5]=0, address in bits[4:0].
REQ-015 Three states: IDLE, WAIT_ADDR, DISPATCH. All outputs registered.
REQ-016 IDLE + rx_done with rx_data[7:4]==0: latch cmd_out<=rx_data[3:0]; go to WAIT_ADDR next cycle; clear timer.
REQ-017 IDLE + rx_done with rx_data[7:4]!=0: pulse cmd_error next cycle; stay IDLE; cmd_out unchanged.
REQ-018 WAIT_ADDR: timer increments each cycle without rx_done.
REQ-019 WAIT_ADDR + rx_done with rx_data[7:3]==0: latch addr_out<=rx_data[4:0]; go to DISPATCH; next cycle cmd_valid = one-hot of rx_data[2:0].
REQ-020 WAIT_ADDR + rx_done with rx_data[7:3]!=0 (address >= 8 or reserved bits set): pulse cmd_error; go to IDLE.
REQ-021 WAIT_ADDR timeout: timer reaches TIMEOUT_CYCLES-1 with no rx_done -> pulse cmd_error; go to IDLE next cycle.
REQ-022 Same cycle as timeout: rx_done takes priority; byte is processed; no timeout error.
REQ-023 DISPATCH: cmd_valid, cmd_out, addr_out held stable until cmd_ack[addr_out[2:0]] sampled high.
REQ-024 Ack sampled: cmd_valid=0 next cycle; go to IDLE. Dispatch latency, address byte rx_done to cmd_valid high: 1 cycle.
REQ-025 cmd_ack bits of non-selected controllers ignored in every state; any cmd_ack in IDLE/WAIT_ADDR ignored.
REQ-026 rx_done in DISPATCH: byte dropped; overrun pulses next cycle; state and outputs unchanged.
REQ-027 rx_done in the same cycle as the accepted ack: byte dropped; overrun pulses; no new frame starts.
REQ-028 No timeout in DISPATCH; wait for ack is unbounded.
REQ-029 cmd_error and overrun never high more than one cycle per event; never high simultaneously.

Reset
REQ-030 rst_n low: immediately state=IDLE, cmd_out=0, addr_out=0, cmd_valid=0, cmd_error=0, overrun=0, busy=0, timer=0.
REQ-031 Reset mid-frame or mid-dispatch: frame discarded; no ack required afterwards; first byte after release is treated as a command byte.

Structure
REQ-032 Shared package/include holds: state encoding, command/address field widths (4, 5), NUM_SENSORS, command-code constants used by sensor controllers.
REQ-033 One sub-module: cmd_timeout_counter (clear, enable, TIMEOUT_CYCLES parameter, expired output); the remainder stays in sensor_cmd_dispatcher.

Verification (TIMEOUT_CYCLES=16 in bench)
REQ-034 rx 0x03 then 0x05, cmd_ack[5] raised 3 cycles after cmd_valid -> cmd_valid=0x20, cmd_out=3, addr_out=5 held until ack; cmd_valid=0 one cycle after ack; busy falls.
REQ-035 rx 0x13 -> cmd_error one-cycle pulse; stays IDLE; no cmd_valid.
REQ-036 rx 0x02 then 0x09 -> cmd_error pulse; IDLE; cmd_valid stays 0.
REQ-037 rx 0x01, no second byte for 16 cycles -> cmd_error pulse; IDLE; then 0x01,0x00 dispatches to cmd_valid=0x01.
REQ-038 During DISPATCH (addr 7): rx 0x04 and pulse cmd_ack[0] -> overrun pulse; cmd_valid stays 0x80 until cmd_ack[7].
REQ-039 rst_n low while in DISPATCH -> all outputs 0 asynchronously; after release, 0x06,0x02 gives cmd_valid=0x04.
